ram_be_init: RTL and testbench
==============================

Name: ram_be_init

Overview:
- Parametrised single-port synchronous RAM; successor to the basic 256x32 ram block.
- Adds per-byte write enables and a selectable 1- or 2-cycle registered read latency with a valid strobe.
- Adds a hardware zero-init sweep after reset and on demand (clear), signalled by busy.
- Used as the generic scratch/data memory beside the datapath; the host must wait for busy=0 before issuing traffic.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of BYTE_W
ADDR_W, 8, address width; depth = 2**ADDR_W words
BYTE_W, 8, bits per byte lane; NB = DATA_W/BYTE_W lanes
READ_LAT, 1, read latency in cycles; legal values 1 or 2 only

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  one-cycle pulse: restart zero-init sweep
cen  in  1  chip enable; request valid when 1
wen  in  1  1 = write, 0 = read (qualified by cen)
be  in  NB  byte-lane write enables, bit i -> din[i*BYTE_W +: BYTE_W]
addr  in  ADDR_W  word address
din  in  DATA_W  write data
dout  out  DATA_W  read data
dvalid  out  1  dout carries the result of a read, one cycle per read
busy  out  1  init sweep in progress; requests ignored

Behaviour:
- Reset (async, active-high): state=INIT, sweep counter=0, busy=1, dvalid=0, dout=0, read pipeline valids=0. The storage array is not reset; the sweep clears it.
- INIT: each cycle writes all-zero to word[counter] (all lanes), then counter++. The write to address 2**ADDR_W-1 moves the state to IDLE. busy=0 from the next cycle.
- Sweep length: exactly 2**ADDR_W cycles from the first rising edge after reset deasserts. Default: 256 cycles.
- IDLE, request accepted when cen=1, busy=0, clear=0:
  - Write (wen=1): for each i with be[i]=1, word[addr] lane i <= din lane i. Other lanes are unchanged. be=0 is a legal no-op.
  - Read (wen=0): samples word[addr] at edge E.
    - READ_LAT=1: dout/dvalid updated at E, visible after E.
    - READ_LAT=2: dout/dvalid updated at E+1.
  - be is ignored on reads.
- dvalid is high for exactly one cycle per accepted read. Back-to-back reads give a continuous dvalid, one read per cycle of throughput.
- dout holds its last value when dvalid=0. It is never cleared except by reset.
- Read-during-write: single port, so impossible in the same cycle. A read in the cycle after a write to the same address returns the new data.
- cen=0: no access; the array and pipeline are unchanged apart from draining in-flight reads.
- clear=1 in any state: state=INIT, counter=0, busy=1 from the next cycle. A request presented in the same cycle as clear is dropped.
- clear while already in INIT: the sweep restarts from address 0.
- Reads in flight when clear or INIT begins still complete with their sampled data (no pipeline flush).
- Requests with busy=1 are silently dropped: no write, no dvalid.
- Reset mid-sweep or mid-read: immediate return to reset values; the sweep restarts after deassertion.

Decomposition:
- Package ram_be_pkg: state enum {INIT, IDLE}, legal READ_LAT constants, NB derivation function.
- Sub-module ram_core: plain storage array with per-lane synchronous write and synchronous registered read, no reset.
- The top level holds the FSM, sweep counter, request qualification, write-data mux (zero/din, be/all-ones), and the optional second read stage.

Test Plan:
- Reset, then release → busy=1 for exactly 256 cycles and 0 after; reads of 0x00, 0x7F and 0xFF all return 0x00000000 with dvalid at the configured latency.
- Write 0x11←0x50, 0x12←0x60, 0x13←0x70, 0x14←0x80 (be=4'hF); then back-to-back reads 0x11..0x15 → dout 0x50, 0x60, 0x70, 0x80, 0x0, with dvalid continuous for 5 cycles. Run with READ_LAT=1 and READ_LAT=2.
- Write 0x20←0xAABBCCDD; write 0x20←0x11223344 with be=4'b0010; read 0x20 → 0xAABB33DD. A write with be=0 leaves the word unchanged.
- Write 0x30←0x5A5A5A5A, read 0x30 on the very next cycle → 0x5A5A5A5A.
- Pulse clear mid-traffic, with a read of 0x11 already in flight → that read returns 0x50. The write issued with clear is dropped. busy=1 for 256 cycles, then read 0x11 → 0x0.
- Assert reset at sweep count ~100 and issue requests while busy=1 → no dvalid, no writes. After release a full 256-cycle sweep runs. dout=0 while in reset.

Source files
------------

// File: rtl/ram_be_pkg.sv
// Shared types and helpers for the byte-enable RAM.
// FSM states, legal read latencies and lane-count derivation.
package ram_be_pkg;

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  localparam int LAT_ONE = 1;
  localparam int LAT_TWO = 2;

  function automatic int nb_of(
    input int data_w,
    input int byte_w
  );
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/ram_be_init_core.sv
// Plain storage array, per-lane synchronous write.
// Registered synchronous read; no reset on storage or read register.
module ram_be_init_core
  import ram_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic                      re,
  input  logic [DATA_W/BYTE_W-1:0]  wmask,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata
);

  localparam int NB = nb_of(DATA_W, BYTE_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Lane-masked write and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && wmask[i]) begin
        mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_be_init.sv
// Single-port RAM with byte enables, zero-init sweep and
// selectable 1/2-cycle read latency with a valid strobe.
module ram_be_init
  import ram_be_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int BYTE_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      cen,
  input  logic                      wen,
  input  logic [DATA_W/BYTE_W-1:0]  be,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      dvalid,
  output logic                      busy
);

  localparam int NB = nb_of(DATA_W, BYTE_W);
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_n;

  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;
  logic [NB-1:0]     mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;
  logic              v1;

  assign busy   = (state == INIT);
  assign acc    = cen & ~busy & ~clear;
  assign wr_acc = acc & wen;
  assign rd_acc = acc & ~wen;

  // Sweep owns the port while busy: zero data, all lanes
  always_comb begin
    mem_we    = wr_acc;
    mem_be    = be;
    mem_addr  = addr;
    mem_wdata = din;
    if (busy) begin
      mem_we    = ~clear;
      mem_be    = '1;
      mem_addr  = cnt;
      mem_wdata = '0;
    end
  end

  // Next state: clear restarts the sweep from any state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (clear) begin
      state_n = INIT;
      cnt_n   = '0;
    end else if (state == INIT) begin
      cnt_n = cnt + 1'b1;
      if (cnt == LAST) begin
        state_n = IDLE;
      end
    end
  end

  // FSM and sweep counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // First read stage valid, aligned with core read register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
    end else begin
      v1 <= rd_acc;
    end
  end

  ram_be_init_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYTE_W (BYTE_W)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .re    (rd_acc),
    .wmask (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  if (READ_LAT == LAT_TWO) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] q2;

    // Second stage: capture only on valid so dout holds
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2 <= 1'b0;
        q2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          q2 <= rdata;
        end
      end
    end

    assign dout   = q2;
    assign dvalid = v2;
  end else begin : g_lat1
    logic seen;

    // Core read register has no reset; mask it until a read lands
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        seen <= 1'b0;
      end else if (rd_acc) begin
        seen <= 1'b1;
      end
    end

    assign dout   = seen ? rdata : '0;
    assign dvalid = v1;
  end

endmodule

// File: tb/tb_ram_be_init.sv
// Directed bench for ram_be_init, both read latencies side by side.
// Table-driven traffic plus hand sequences for clear and reset.
module tb_ram_be_init;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        cen;
  logic        wen;
  logic [3:0]  be;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout1;
  logic [31:0] dout2;
  logic        dvalid1;
  logic        dvalid2;
  logic        busy1;
  logic        busy2;

  always #5 clk = ~clk;

  ram_be_init #(.READ_LAT(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear),
    .cen(cen), .wen(wen), .be(be),
    .addr(addr), .din(din), .dout(dout1),
    .dvalid(dvalid1), .busy(busy1)
  );

  ram_be_init #(.READ_LAT(2)) u2 (
    .clk(clk), .reset(reset), .clear(clear),
    .cen(cen), .wen(wen), .be(be),
    .addr(addr), .din(din), .dout(dout2),
    .dvalid(dvalid2), .busy(busy2)
  );

  typedef struct {
    logic        cen;
    logic        wen;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        c,
    input logic        w,
    input logic [3:0]  b,
    input logic [7:0]  a,
    input logic [31:0] d
  );
    clear = 1'b0;
    cen   = c;
    wen   = w;
    be    = b;
    addr  = a;
    din   = d;
  endtask

  task automatic count_busy(
    input string      nm,
    input logic [7:0] wa
  );
    int   n    = 0;
    logic sawv = 1'b0;
    logic diff = 1'b0;
    while (busy1 && n < 1000) begin
      if (n >= 100) drive(1, 1, 4'hF, wa, 32'hFFFF_FFFF);
      else          drive(1, 0, 4'h0, 8'h11, 32'h0);
      step();
      n++;
      if (dvalid1 || dvalid2) sawv = 1'b1;
      if (busy1 !== busy2)    diff = 1'b1;
    end
    drive(0, 0, 4'h0, 8'h00, 32'h0);
    chk({nm, " busy cycles"}, n, 256);
    chk({nm, " dvalid while busy"}, {31'd0, sawv}, 0);
    chk({nm, " busy agree"}, {31'd0, diff}, 0);
  endtask

  task automatic add(
    input logic c, w, input logic [3:0] b,
    input logic [7:0] a, input logic [31:0] d,
    input logic v1, input logic [31:0] d1,
    input logic v2, input logic [31:0] d2
  );
    vec_t r;
    r = '{c, w, b, a, d, v1, d1, v2, d2};
    tv.push_back(r);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 4'h0, 8'h00, 32'h0);

    add(1,0,4'h0,8'h00,0,            1,0,          0,0);
    add(1,0,4'h0,8'h7F,0,            1,0,          1,0);
    add(1,0,4'h0,8'hFF,0,            1,0,          1,0);
    add(1,0,4'h0,8'h05,0,            1,0,          1,0);
    add(0,0,4'h0,8'h00,0,            0,0,          1,0);
    add(1,1,4'hF,8'h11,32'h50,       0,0,          0,0);
    add(1,1,4'hF,8'h12,32'h60,       0,0,          0,0);
    add(1,1,4'hF,8'h13,32'h70,       0,0,          0,0);
    add(1,1,4'hF,8'h14,32'h80,       0,0,          0,0);
    add(1,0,4'h0,8'h11,0,            1,32'h50,     0,0);
    add(1,0,4'h0,8'h12,0,            1,32'h60,     1,32'h50);
    add(1,0,4'h0,8'h13,0,            1,32'h70,     1,32'h60);
    add(1,0,4'h0,8'h14,0,            1,32'h80,     1,32'h70);
    add(1,0,4'h0,8'h15,0,            1,0,          1,32'h80);
    add(0,0,4'h0,8'h00,0,            0,0,          1,0);
    add(0,0,4'h0,8'h00,0,            0,0,          0,0);
    add(1,1,4'hF,8'h20,32'hAABBCCDD, 0,0,          0,0);
    add(1,1,4'h2,8'h20,32'h11223344, 0,0,          0,0);
    add(1,1,4'h0,8'h20,32'hFFFFFFFF, 0,0,          0,0);
    add(1,0,4'h0,8'h20,0,            1,32'hAABB33DD,0,0);
    add(1,1,4'hF,8'h30,32'h5A5A5A5A, 0,32'hAABB33DD,1,32'hAABB33DD);
    add(1,0,4'h0,8'h30,0,            1,32'h5A5A5A5A,0,32'hAABB33DD);
    add(0,0,4'h0,8'h00,0,            0,32'h5A5A5A5A,1,32'h5A5A5A5A);
    add(0,0,4'h0,8'h00,0,            0,32'h5A5A5A5A,0,32'h5A5A5A5A);

    // Power-on reset and first sweep
    step();
    step();
    chk("rst busy", {31'd0, busy1}, 1);
    chk("rst dvalid", {30'd0, dvalid1, dvalid2}, 0);
    chk("rst dout1", dout1, 0);
    chk("rst dout2", dout2, 0);
    reset = 1'b0;
    count_busy("init", 8'h05);

    // Main traffic table
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].cen, tv[i].wen, tv[i].be,
            tv[i].addr, tv[i].din);
      step();
      chk($sformatf("r%0d dv1", i), {31'd0, dvalid1}, {31'd0, tv[i].v1});
      chk($sformatf("r%0d dout1", i), dout1, tv[i].d1);
      chk($sformatf("r%0d dv2", i), {31'd0, dvalid2}, {31'd0, tv[i].v2});
      chk($sformatf("r%0d dout2", i), dout2, tv[i].d2);
    end

    // Clear with a read in flight and a write alongside it
    drive(1, 0, 4'h0, 8'h11, 0);
    step();
    chk("clr rd dv1", {31'd0, dvalid1}, 1);
    chk("clr rd dout1", dout1, 32'h50);
    drive(1, 1, 4'hF, 8'h11, 32'hDEADBEEF);
    clear = 1'b1;
    step();
    chk("clr dv1", {31'd0, dvalid1}, 0);
    chk("clr dout1 hold", dout1, 32'h50);
    chk("clr dv2", {31'd0, dvalid2}, 1);
    chk("clr dout2", dout2, 32'h50);
    chk("clr busy", {31'd0, busy1}, 1);
    count_busy("clr", 8'h05);
    drive(1, 0, 4'h0, 8'h11, 0);
    step();
    chk("post clr dv1", {31'd0, dvalid1}, 1);
    chk("post clr 11", dout1, 0);
    drive(1, 0, 4'h0, 8'h05, 0);
    step();
    chk("post clr 05", dout1, 0);
    chk("post clr dout2", dout2, 0);

    // Reset in the middle of a sweep
    drive(1, 1, 4'hF, 8'h30, 32'h5A5A5A5A);
    step();
    drive(1, 0, 4'h0, 8'h30, 0);
    step();
    chk("pre rst dout1", dout1, 32'h5A5A5A5A);
    drive(0, 0, 4'h0, 8'h00, 0);
    step();
    chk("pre rst dout2", dout2, 32'h5A5A5A5A);
    clear = 1'b1;
    step();
    drive(0, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 100; i++) step();
    chk("mid sweep busy", {31'd0, busy1}, 1);
    chk("mid sweep dout1", dout1, 32'h5A5A5A5A);
    chk("mid sweep dout2", dout2, 32'h5A5A5A5A);
    reset = 1'b1;
    #1;
    chk("async dout1", dout1, 0);
    chk("async dout2", dout2, 0);
    chk("async busy", {31'd0, busy1}, 1);
    drive(1, 0, 4'h0, 8'h30, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("in rst dv", {30'd0, dvalid1, dvalid2}, 0);
    end
    reset = 1'b0;
    count_busy("rst2", 8'h06);
    drive(1, 0, 4'h0, 8'h30, 0);
    step();
    chk("post rst dv1", {31'd0, dvalid1}, 1);
    chk("post rst 30", dout1, 0);
    drive(1, 0, 4'h0, 8'h06, 0);
    step();
    chk("post rst 06", dout1, 0);
    drive(0, 0, 4'h0, 8'h00, 0);
    step();
    chk("post rst dv2", {31'd0, dvalid2}, 1);
    chk("post rst dout2", dout2, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
